// File: rtl/ami_pkg.sv
// Shared types for the ami DMA command path: the command record carried by
// each output slot and the default requester count.
package ami_pkg;

    localparam int NREQ_DEF = 4;
    localparam int SRC_W    = 8;

    // src is sized for the largest supported requester count; unused upper
    // bits are always zero.
    typedef struct packed {
        logic [31:0]      sa;
        logic [31:0]      len;
        logic [SRC_W-1:0] src;
    } cmd_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: first set bit of elig_i searching upward from ptr_i,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] win_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant_o = '0;
        win_o   = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (!found && elig_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                win_o        = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ami_dma_sched.sv
// Schedules DMA commands from NREQ requesters into one write and one read
// command slot toward ami, round-robin, one acceptance per cycle.
module ami_dma_sched
    import ami_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*32-1:0]   req_sa,
    input  logic [NREQ*32-1:0]   req_len,
    output logic                 cfg_dmaw_valid,
    input  logic                 cfg_dmaw_ready,
    output logic [31:0]          cfg_dmaw_sa,
    output logic [31:0]          cfg_dmaw_len,
    output logic [IDW-1:0]       cfg_dmaw_src,
    output logic                 cfg_dmar_valid,
    input  logic                 cfg_dmar_ready,
    output logic [31:0]          cfg_dmar_sa,
    output logic [31:0]          cfg_dmar_len,
    output logic [IDW-1:0]       cfg_dmar_src,
    output logic                 zlen_drop,
    output logic                 idle
);

    logic [31:0]     sa_a  [NREQ];
    logic [31:0]     len_a [NREQ];
    logic [NREQ-1:0] zlen;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic            w_free, r_free;
    logic            win_w, win_r, win_z;
    cmd_t            win_cmd;

    logic            w_vld_q, w_vld_d, r_vld_q, r_vld_d;
    cmd_t            w_cmd_q, w_cmd_d, r_cmd_q, r_cmd_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            zlen_q, zlen_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            sa_a[i]  = req_sa[i*32 +: 32];
            len_a[i] = req_len[i*32 +: 32];
            zlen[i]  = (req_len[i*32 +: 32] == 32'd0);
        end
    end

    // A slot can take a new command this cycle if empty or draining now.
    assign w_free = !w_vld_q || cfg_dmaw_ready;
    assign r_free = !r_vld_q || cfg_dmar_ready;

    // Zero-length commands never occupy a slot, so they bypass the free check.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = !reset && req_valid[i] &&
                      (zlen[i] || (req_wr[i] ? w_free : r_free));
        end
    end

    rr_arb #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .win_o   (win_idx),
        .any_o   (win_any)
    );

    assign req_ready = grant;

    always_comb begin
        win_cmd.sa  = sa_a[win_idx];
        win_cmd.len = len_a[win_idx];
        win_cmd.src = SRC_W'(win_idx);
        win_z       = win_any && zlen[win_idx];
        win_w       = win_any && !zlen[win_idx] && req_wr[win_idx];
        win_r       = win_any && !zlen[win_idx] && !req_wr[win_idx];
    end

    // Handshake-out clears first; a same-cycle reload then overrides it.
    always_comb begin
        w_vld_d = w_vld_q;
        w_cmd_d = w_cmd_q;
        r_vld_d = r_vld_q;
        r_cmd_d = r_cmd_q;
        if (cfg_dmaw_valid && cfg_dmaw_ready) w_vld_d = 1'b0;
        if (cfg_dmar_valid && cfg_dmar_ready) r_vld_d = 1'b0;
        if (win_w) begin
            w_vld_d = 1'b1;
            w_cmd_d = win_cmd;
        end
        if (win_r) begin
            r_vld_d = 1'b1;
            r_cmd_d = win_cmd;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_any) begin
            ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
        end
        zlen_d = win_z;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_vld_q <= 1'b0;
            r_vld_q <= 1'b0;
            w_cmd_q <= '0;
            r_cmd_q <= '0;
            ptr_q   <= '0;
            zlen_q  <= 1'b0;
        end else begin
            w_vld_q <= w_vld_d;
            r_vld_q <= r_vld_d;
            w_cmd_q <= w_cmd_d;
            r_cmd_q <= r_cmd_d;
            ptr_q   <= ptr_d;
            zlen_q  <= zlen_d;
        end
    end

    assign cfg_dmaw_valid = w_vld_q;
    assign cfg_dmaw_sa    = w_cmd_q.sa;
    assign cfg_dmaw_len   = w_cmd_q.len;
    assign cfg_dmaw_src   = w_cmd_q.src[IDW-1:0];
    assign cfg_dmar_valid = r_vld_q;
    assign cfg_dmar_sa    = r_cmd_q.sa;
    assign cfg_dmar_len   = r_cmd_q.len;
    assign cfg_dmar_src   = r_cmd_q.src[IDW-1:0];
    assign zlen_drop      = zlen_q;
    assign idle           = !w_vld_q && !r_vld_q && (req_valid == '0);

    // Upper src bits are always zero; folded here so they count as read.
    logic unused_src;
    assign unused_src = ^{w_cmd_q.src, r_cmd_q.src};

endmodule

// File: tb/tb_ami_dma_sched.sv
// Scoreboard bench for ami_dma_sched: expected commands are queued as they
// are driven and popped when the matching cfg_dma handshake occurs.
module tb_ami_dma_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid, req_ready, req_wr;
    logic [NREQ*32-1:0]  req_sa, req_len;
    logic                cfg_dmaw_valid, cfg_dmaw_ready;
    logic [31:0]         cfg_dmaw_sa, cfg_dmaw_len;
    logic [IDW-1:0]      cfg_dmaw_src;
    logic                cfg_dmar_valid, cfg_dmar_ready;
    logic [31:0]         cfg_dmar_sa, cfg_dmar_len;
    logic [IDW-1:0]      cfg_dmar_src;
    logic                zlen_drop, idle;

    typedef struct {
        logic [31:0]    sa;
        logic [31:0]    len;
        logic [IDW-1:0] src;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ami_dma_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_sa         (req_sa),
        .req_len        (req_len),
        .cfg_dmaw_valid (cfg_dmaw_valid),
        .cfg_dmaw_ready (cfg_dmaw_ready),
        .cfg_dmaw_sa    (cfg_dmaw_sa),
        .cfg_dmaw_len   (cfg_dmaw_len),
        .cfg_dmaw_src   (cfg_dmaw_src),
        .cfg_dmar_valid (cfg_dmar_valid),
        .cfg_dmar_ready (cfg_dmar_ready),
        .cfg_dmar_sa    (cfg_dmar_sa),
        .cfg_dmar_len   (cfg_dmar_len),
        .cfg_dmar_src   (cfg_dmar_src),
        .zlen_drop      (zlen_drop),
        .idle           (idle)
    );

    // Scoreboard consumer: every output handshake must match the queue head.
    always @(negedge clk) begin
        if (!reset && cfg_dmaw_valid && cfg_dmaw_ready) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL w_unexpected: got sa=%h len=%h src=%0d, expected no command",
                         cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src);
            end else begin
                exp_t e;
                e = wq.pop_front();
                if ({cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src} !== {e.sa, e.len, e.src}) begin
                    errors++;
                    $display("FAIL w_cmd: got sa=%h len=%h src=%0d, expected sa=%h len=%h src=%0d",
                             cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src, e.sa, e.len, e.src);
                end
            end
        end
        if (!reset && cfg_dmar_valid && cfg_dmar_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected: got sa=%h len=%h src=%0d, expected no command",
                         cfg_dmar_sa, cfg_dmar_len, cfg_dmar_src);
            end else begin
                exp_t e;
                e = rq.pop_front();
                if ({cfg_dmar_sa, cfg_dmar_len, cfg_dmar_src} !== {e.sa, e.len, e.src}) begin
                    errors++;
                    $display("FAIL r_cmd: got sa=%h len=%h src=%0d, expected sa=%h len=%h src=%0d",
                             cfg_dmar_sa, cfg_dmar_len, cfg_dmar_src, e.sa, e.len, e.src);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [31:0] sa, input logic [31:0] len);
        req_valid[i]       = v;
        req_wr[i]          = wr;
        req_sa[i*32 +: 32]  = sa;
        req_len[i*32 +: 32] = len;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        req_valid      = '1;
        req_wr         = '1;
        req_sa         = {4{32'h0000_1111}};
        req_len        = {4{32'h0000_0040}};
        cfg_dmaw_ready = 1'b0;
        cfg_dmar_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_ready: got %b, expected 0000", req_ready);
        end
        step();
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({cfg_dmaw_valid, cfg_dmar_valid, zlen_drop, idle} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_flags: got wv,rv,zd,idle=%b, expected 0001",
                     {cfg_dmaw_valid, cfg_dmar_valid, zlen_drop, idle});
        end
        checks++;
        if ({cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src, cfg_dmar_sa, cfg_dmar_len, cfg_dmar_src} !== '0) begin
            errors++;
            $display("FAIL rst_fields: got w sa=%h len=%h src=%0d r sa=%h len=%h src=%0d, expected all 0",
                     cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src, cfg_dmar_sa, cfg_dmar_len, cfg_dmar_src);
        end
    endtask

    task automatic test_single_write();
        step();
        set_req(0, 1'b1, 1'b1, 32'h1000, 32'h400);
        wq.push_back('{sa: 32'h1000, len: 32'h400, src: 2'd0});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b, expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_ready_pulse: got %b, expected 0000", req_ready);
        end
        checks++;
        if ({cfg_dmaw_valid, cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src, cfg_dmar_valid} !==
            {1'b1, 32'h1000, 32'h400, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_slot: got wv=%b sa=%h len=%h src=%0d rv=%b, expected wv=1 sa=1000 len=400 src=0 rv=0",
                     cfg_dmaw_valid, cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src, cfg_dmar_valid);
        end
        step();
        cfg_dmaw_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if ({cfg_dmaw_valid, idle} !== 2'b01) begin
            errors++;
            $display("FAIL single_drain: got wv,idle=%b, expected 01", {cfg_dmaw_valid, idle});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        step();
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 32'h2000 + i*32'h100, 32'h40 + i);
        for (int k = 0; k < 8; k++) begin
            wq.push_back('{sa: 32'h2000 + (k%4)*32'h100, len: 32'h40 + (k%4), src: IDW'(k%4)});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", k, req_ready, exp_g);
            end
            if (k > 0) begin
                checks++;
                if (cfg_dmaw_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_no_gap[%0d]: got wv=%b, expected 1", k, cfg_dmaw_valid);
                end
            end
            if (k < 7) step();
        end
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if ({cfg_dmaw_valid, wq.size() == 0} !== 2'b01) begin
            errors++;
            $display("FAIL rr_drain: got wv=%b pending=%0d, expected wv=0 pending=0",
                     cfg_dmaw_valid, wq.size());
        end
    endtask

    task automatic test_zlen_drop();
        step();
        set_req(3, 1'b1, 1'b1, 32'h5000, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL zlen_grant: got %b, expected 1000", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({zlen_drop, cfg_dmaw_valid, cfg_dmar_valid} !== 3'b100) begin
            errors++;
            $display("FAIL zlen_pulse: got zd,wv,rv=%b, expected 100",
                     {zlen_drop, cfg_dmaw_valid, cfg_dmar_valid});
        end
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 32'h6000 + i*32'h10, 32'h20);
        wq.push_back('{sa: 32'h6000, len: 32'h20, src: 2'd0});
        @(negedge clk);
        checks++;
        if ({req_ready, zlen_drop} !== 5'b0001_0) begin
            errors++;
            $display("FAIL zlen_ptr: got ready=%b zd=%b, expected ready=0001 zd=0", req_ready, zlen_drop);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL zlen_idle: got %b, expected 1", idle);
        end
    endtask

    task automatic test_no_hol();
        step();
        cfg_dmaw_ready = 1'b0;
        cfg_dmar_ready = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h3000, 32'h10);
        wq.push_back('{sa: 32'h3000, len: 32'h10, src: 2'd0});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL hol_fill: got %b, expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 32'h3100, 32'h20);
        set_req(2, 1'b1, 1'b0, 32'h7000, 32'h80);
        rq.push_back('{sa: 32'h7000, len: 32'h80, src: 2'd2});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL hol_grant: got %b, expected 0100", req_ready);
        end
        step();
        req_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL hol_stall: got %b, expected 0000", req_ready);
        end
        checks++;
        if ({cfg_dmar_valid, cfg_dmar_sa, cfg_dmar_src} !== {1'b1, 32'h7000, 2'd2}) begin
            errors++;
            $display("FAIL hol_rslot: got rv=%b sa=%h src=%0d, expected rv=1 sa=7000 src=2",
                     cfg_dmar_valid, cfg_dmar_sa, cfg_dmar_src);
        end
        checks++;
        if ({cfg_dmaw_valid, cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src} !== {1'b1, 32'h3000, 32'h10, 2'd0}) begin
            errors++;
            $display("FAIL hol_wslot: got wv=%b sa=%h len=%h src=%0d, expected wv=1 sa=3000 len=10 src=0",
                     cfg_dmaw_valid, cfg_dmaw_sa, cfg_dmaw_len, cfg_dmaw_src);
        end
        // Releasing W ready lets the stalled req1 reload the slot as it drains.
        step();
        cfg_dmaw_ready = 1'b1;
        wq.push_back('{sa: 32'h3100, len: 32'h20, src: 2'd1});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL hol_b2b_grant: got %b, expected 0010", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        cfg_dmaw_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        step();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h8000, 32'h8);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b, expected 0000", req_ready);
        end
        step();
        reset     = 1'b0;
        req_valid = '0;
        rq.delete();
        @(negedge clk);
        checks++;
        if ({cfg_dmar_valid, idle} !== 2'b01) begin
            errors++;
            $display("FAIL mid_rst_clear: got rv,idle=%b, expected 01", {cfg_dmar_valid, idle});
        end
        step();
        cfg_dmar_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 32'h9000 + i*32'h10, 32'h8);
        rq.push_back('{sa: 32'h9000, len: 32'h8, src: 2'd0});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_rst_first: got %b, expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_idle: got %b, expected 1", idle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_zlen_drop();
        test_no_hol();
        test_reset_mid();
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got w=%0d r=%0d pending, expected 0 0", wq.size(), rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
